// File: rtl/router_pkg.sv
// Shared types and header helpers for the router packet transmitter.
package router_pkg;

    localparam int unsigned HDR_LEN_W  = 6;
    localparam int unsigned HDR_ADDR_W = 2;

    localparam logic [HDR_ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StDone
    } tx_state_t;

    function automatic logic [7:0] pack_header(input logic [HDR_LEN_W-1:0]  len,
                                               input logic [HDR_ADDR_W-1:0] dest);
        return {len, dest};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: synchronous write, asynchronous read register array.
module router_tx_buf #(
    parameter int unsigned Depth = 63,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Addresses past the last entry read as zero instead of out of range.
    assign rdata = (32'(raddr) < Depth) ? mem_q[raddr] : 8'h00;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header, payload and parity.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_err to corrupt parity bit 0 per packet.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic                  inj_err,
`endif
    input  logic                  start,
    input  logic [HDR_ADDR_W-1:0] dest,
    input  logic [HDR_LEN_W-1:0]  len,
    input  logic                  pl_valid,
    input  logic [7:0]            pl_data,
    output logic                  pl_ready,
    input  logic                  busy,
    output logic                  pkt_valid,
    output logic [7:0]            data_out,
    output logic                  idle,
    output logic                  done,
    output logic                  bad_req
);

    localparam int unsigned AW = $clog2(MAX_LEN);

    tx_state_t             state_q, state_d;
    logic [HDR_LEN_W-1:0]  cnt_q, cnt_d;
    logic [HDR_LEN_W-1:0]  len_q, len_d;
    logic [HDR_ADDR_W-1:0] dest_q, dest_d;
    logic [7:0]            parity_q, parity_d;
    logic [7:0]            data_q, data_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic                  bad_req_q, bad_req_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic                  inj_q, inj_d;
`endif

    logic                  buf_we;
    logic [AW-1:0]         buf_raddr;
    logic [7:0]            buf_rdata;
    logic                  last;
    logic [7:0]            parity_out;

    router_tx_buf #(
        .Depth (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (AW'(cnt_q)),
        .wdata (pl_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    assign last = (cnt_q == len_q - 6'd1);
    // Look one byte ahead so data_out can be registered on each transfer.
    assign buf_raddr = (state_q == StPayload) ? AW'(cnt_q + 6'd1) : AW'(cnt_q);

`ifdef ROUTER_TX_PARITY_INJ_EN
    assign parity_out = parity_q ^ {7'b0, inj_q};
`else
    assign parity_out = parity_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        dest_d      = dest_q;
        parity_d    = parity_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        bad_req_d   = 1'b0;
        buf_we      = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_d       = inj_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dest == ADDR_INVALID || len == '0) begin
                        bad_req_d = 1'b1;
                    end else begin
                        state_d  = StLoad;
                        dest_d   = dest;
                        len_d    = len;
                        cnt_d    = '0;
                        parity_d = pack_header(len, dest);
`ifdef ROUTER_TX_PARITY_INJ_EN
                        inj_d    = inj_err;
`endif
                    end
                end
            end
            StLoad: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ pl_data;
                    if (last) begin
                        state_d     = StHeader;
                        cnt_d       = '0;
                        pkt_valid_d = 1'b1;
                        data_d      = pack_header(len_q, dest_q);
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            StHeader: begin
                if (!busy) begin
                    state_d = StPayload;
                    data_d  = buf_rdata;
                end
            end
            StPayload: begin
                if (!busy) begin
                    if (last) begin
                        state_d     = StParity;
                        pkt_valid_d = 1'b0;
                        data_d      = parity_out;
                    end else begin
                        cnt_d  = cnt_q + 6'd1;
                        data_d = buf_rdata;
                    end
                end
            end
            StParity: begin
                if (!busy) begin
                    state_d = StDone;
                    data_d  = 8'h00;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            dest_q      <= '0;
            parity_q    <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            bad_req_q   <= 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            parity_q    <= parity_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            bad_req_q   <= bad_req_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
            inj_q       <= inj_d;
`endif
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_q;
    assign bad_req   = bad_req_q;
    assign pl_ready  = (state_q == StLoad);
    assign idle      = (state_q == StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a byte scoreboard on the router side.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [5:0] len = 6'd0;
    logic       pl_valid = 1'b0;
    logic [7:0] pl_data = 8'h00;
    logic       busy = 1'b0;
    logic       pl_ready, pkt_valid, idle, done, bad_req;
    logic [7:0] data_out;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       inj_err = 1'b0;
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay [64];
    int         pv_hi = 0;
    int         done_cnt = 0;
    int         ld_cycles = 0;
    logic       in_pkt = 1'b0;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .MAX_LEN (63)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ROUTER_TX_PARITY_INJ_EN
        .inj_err   (inj_err),
`endif
        .start     (start),
        .dest      (dest),
        .len       (len),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .idle      (idle),
        .done      (done),
        .bad_req   (bad_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Router side: a byte transfers at the next rising edge when busy is low.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            in_pkt = 1'b0;
        end else begin
            if (pl_ready) ld_cycles++;
            if (done) done_cnt++;
            if (pkt_valid) pv_hi++;
            if (!busy && (pkt_valid || in_pkt)) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL xfer_extra: got %0h want no byte", data_out);
                end
                if (exp_q.size() > 0) chk("xfer_byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                in_pkt = pkt_valid;
            end
        end
    end

    task automatic send(input logic [1:0] d, input logic [5:0] n, input bit gaps, input bit inj);
        logic [7:0] p;
        @(negedge clk);
        dest  = d;
        len   = n;
        start = 1'b1;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_err = inj;
`endif
        p = {n, d};
        exp_q.push_back(p);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(pay[i]);
            p = p ^ pay[i];
        end
        p[0] = p[0] ^ inj;
        exp_q.push_back(p);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            chk("pl_ready", {31'h0, pl_ready}, 32'd1);
            pl_valid = 1'b1;
            pl_data  = pay[i];
            @(negedge clk);
            if (gaps && i != int'(n) - 1) begin
                pl_valid = 1'b0;
                @(negedge clk);
            end
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        total++;
        assert (done_cnt != d0) else begin
            bad++;
            $error("FAIL %s: got done_cnt=%0d want >%0d within %0d cycles", tag, done_cnt, d0,
                   budget);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d0, p0, l0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_pkt_valid", {31'h0, pkt_valid}, 32'd0);
        chk("rst_data_out", {24'h0, data_out}, 32'd0);
        chk("rst_pl_ready", {31'h0, pl_ready}, 32'd0);
        chk("rst_idle", {31'h0, idle}, 32'd1);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_bad_req", {31'h0, bad_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic packet, busy tied low
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        d0 = done_cnt; p0 = pv_hi; l0 = ld_cycles;
        send(2'd1, 6'd3, 1'b0, 1'b0);
        chk("hdr_value", {24'h0, data_out}, 32'h0d);
        wait_done("basic_done", 20);
        chk("basic_done_once", done_cnt - d0, 32'd1);
        chk("basic_pv_cycles", pv_hi - p0, 32'd4);
        chk("basic_load_cycles", ld_cycles - l0, 32'd3);
        chk("basic_q_empty", exp_q.size(), 32'd0);
        chk("basic_idle", {31'h0, idle}, 32'd1);

        // Same packet with busy held for 3 cycles on byte 0x22
        d0 = done_cnt; p0 = pv_hi;
        send(2'd1, 6'd3, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !(pkt_valid && data_out == 8'h22); i++) @(negedge clk);
        chk("busy_reach", {24'h0, data_out}, 32'h22);
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_hold_data", {24'h0, data_out}, 32'h22);
            chk("busy_hold_valid", {31'h0, pkt_valid}, 32'd1);
        end
        busy = 1'b0;
        wait_done("busy_done", 20);
        chk("busy_done_once", done_cnt - d0, 32'd1);
        chk("busy_pv_cycles", pv_hi - p0, 32'd7);
        chk("busy_q_empty", exp_q.size(), 32'd0);

        // Rejected requests
        for (int r = 0; r < 2; r++) begin
            p0 = pv_hi;
            @(negedge clk);
            dest  = (r == 0) ? 2'd3 : 2'd1;
            len   = (r == 0) ? 6'd4 : 6'd0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("rej_bad_req", {31'h0, bad_req}, 32'd1);
            chk("rej_idle", {31'h0, idle}, 32'd1);
            @(negedge clk);
            chk("rej_bad_req_drop", {31'h0, bad_req}, 32'd0);
            chk("rej_idle_hold", {31'h0, idle}, 32'd1);
            repeat (3) @(negedge clk);
            chk("rej_no_valid", pv_hi - p0, 32'd0);
        end

        // Max length with pl_valid toggling
        for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(0, 255));
        d0 = done_cnt; l0 = ld_cycles;
        send(2'd2, 6'd63, 1'b1, 1'b0);
        chk("max_load_cycles", ld_cycles - l0, 32'd125);
        wait_done("max_done", 200);
        chk("max_done_once", done_cnt - d0, 32'd1);
        chk("max_q_empty", exp_q.size(), 32'd0);

        // Reset during payload, then a short packet
        for (int i = 0; i < 5; i++) pay[i] = 8'(8'h40 + i);
        send(2'd2, 6'd5, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        chk("midrst_pkt_valid", {31'h0, pkt_valid}, 32'd0);
        chk("midrst_idle", {31'h0, idle}, 32'd1);
        chk("midrst_data_out", {24'h0, data_out}, 32'd0);
        pay[0] = 8'h5a; pay[1] = 8'hc3;
        d0 = done_cnt;
        send(2'd0, 6'd2, 1'b0, 1'b0);
        wait_done("after_rst_done", 20);
        chk("after_rst_done_once", done_cnt - d0, 32'd1);
        chk("after_rst_q_empty", exp_q.size(), 32'd0);

`ifdef ROUTER_TX_PARITY_INJ_EN
        // Injected parity error
        pay[0] = 8'ha5;
        send(2'd0, 6'd1, 1'b0, 1'b1);
        wait_done("inj_done", 20);
        chk("inj_q_empty", exp_q.size(), 32'd0);
        inj_err = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
